// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word data-memory responder with programmable wait states
// Optional byte-strobe stores are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] idx;
    logic              bad;
    logic              commit;
    logic              wr_en;
    logic [3:0]        req_be_w;

`ifdef DMEM_BYTE_STROBE_EN
    assign req_be_w = req_be;
`else
    assign req_be_w = 4'hF;
`endif

    // All decode works on the latched request so WAIT/RESP ignore live inputs.
    assign idx    = addr_q[ADDR_W+1:2];
    assign bad    = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign commit = (state_q == WAIT) && (cnt_q == 8'(WAIT_CYCLES));
    assign wr_en  = commit && we_q && !bad;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be_w;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (commit) begin
                    cnt_d   = 8'd0;
                    err_d   = bad;
                    rdata_d = (!we_q && !bad) ? mem[idx] : 32'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset; a write only happens on the commit edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table-driven bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic        resp_err  [2];
    logic [31:0] resp_rdata[2];
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_be;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be(req_be),
`endif
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .ADDR_W(10)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be(req_be),
`endif
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    typedef struct {
        int          sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic        early;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_req(input vec_t v);
        int s;
        int lat;
        s = v.sel;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[s]), 32'd1);
        req_we       = v.we;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
`ifdef DMEM_BYTE_STROBE_EN
        req_be       = v.be;
`endif
        req_valid[s]  = 1'b1;
        resp_ready[s] = v.early;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        req_we       = ~v.we;
        req_addr     = 32'hFFFF_FFF3;
        req_wdata    = 32'h0BAD_0BAD;
        chk("req_ready_busy", 32'(req_ready[s]), 32'd0);
        lat = 0;
        while (!resp_valid[s] && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), (s == 0) ? 32'd3 : 32'd1);
        chk("resp_rdata", resp_rdata[s], v.exp_rdata);
        chk("resp_err", 32'(resp_err[s]), 32'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(resp_valid[s]), 32'd1);
            chk("hold_rdata", resp_rdata[s], v.exp_rdata);
            chk("hold_req_ready", 32'(req_ready[s]), 32'd0);
        end
        resp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[s] = 1'b0;
        chk("consumed_valid", 32'(resp_valid[s]), 32'd0);
        chk("consumed_ready", 32'(req_ready[s]), 32'd1);
        chk("consumed_rdata", resp_rdata[s], 32'd0);
        chk("consumed_err", 32'(resp_err[s]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        resp_ready[0] = 1'b0; resp_ready[1] = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
        req_be = 4'hF;
`endif

        //           sel we  addr         wdata          be    hold early exp_rdata     err
        tv.push_back('{0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 32'h10,   32'h0,        4'hF, 5, 1'b0, 32'hDEADBEEF, 1'b0});
        tv.push_back('{0, 1'b1, 32'h13,   32'h55555555, 4'hF, 0, 1'b0, 32'h0,        1'b1});
        tv.push_back('{0, 1'b0, 32'h10,   32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF, 1'b0});
        tv.push_back('{0, 1'b0, 32'h1000, 32'h0,        4'hF, 0, 1'b1, 32'h0,        1'b1});
        tv.push_back('{0, 1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 0, 1'b0, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 32'hFFC,  32'h0,        4'hF, 0, 1'b0, 32'hCAFEF00D, 1'b0});
        tv.push_back('{0, 1'b0, 32'h2,    32'h0,        4'hF, 0, 1'b0, 32'h0,        1'b1});
        tv.push_back('{0, 1'b1, 32'h20,   32'h0,        4'hF, 0, 1'b0, 32'h0,        1'b0});
        tv.push_back('{1, 1'b1, 32'h40,   32'h600DF00D, 4'hF, 0, 1'b0, 32'h0,        1'b0});
        tv.push_back('{1, 1'b0, 32'h40,   32'h0,        4'hF, 0, 1'b0, 32'h600DF00D, 1'b0});
        tv.push_back('{1, 1'b0, 32'h45,   32'h0,        4'hF, 0, 1'b1, 32'h0,        1'b1});
`ifdef DMEM_BYTE_STROBE_EN
        tv.push_back('{0, 1'b1, 32'h30,   32'h11223344, 4'hF, 0, 1'b0, 32'h0,        1'b0});
        tv.push_back('{0, 1'b1, 32'h30,   32'hAABBCCDD, 4'h5, 0, 1'b0, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 32'h30,   32'h0,        4'h0, 0, 1'b0, 32'h11BB33DD, 1'b0});
        tv.push_back('{0, 1'b1, 32'h30,   32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0,        1'b0});
        tv.push_back('{0, 1'b0, 32'h30,   32'h0,        4'hF, 0, 1'b0, 32'h11BB33DD, 1'b0});
`endif

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
            chk("rst_resp_rdata", resp_rdata[s], 32'd0);
            chk("rst_resp_err", 32'(resp_err[s]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) do_req(tv[i]);

        // Abort a store to 0x20 while it is still waiting.
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("abort_resp_rdata", resp_rdata[0], 32'd0);
        chk("abort_resp_err", 32'(resp_err[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (5) begin
                @(posedge clk);
                #1;
                seen = seen | resp_valid[0];
            end
            chk("abort_no_resp", 32'(seen), 32'd0);
        end
        do_req('{0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
